data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Responder end of the core's data-memory request interface. Accepts one load or store request
//  (request/we_re/mask/address/store_data) from the memory stage and performs the byte-masked write
//  or full-word read on a local word array. Returns one-cycle data_valid with load_data after a
//  parameterised latency. Sits between the core's memory stage and the data RAM in the SoC top.
// PARAMETERS
//  DataWidth  32    data and address width; the byte-lane count is DataWidth/8 (fixed at 4).
//  Depth      1024  number of words in the array; must be a power of two.
//  Latency    2     cycles from the accept edge to data_valid; legal range is 1..15.
// PORTS
//  clk         in   1          clock; all logic is on the rising edge.
//  rst         in   1          synchronous, active-low reset.
//  request     in   1          transaction request; held by the initiator until data_valid.
//  we_re       in   1          1 = store, 0 = load; qualified by request.
//  mask        in   4          byte-lane write enables; bit i selects bits [8i+7:8i]; ignored on loads.
//  address     in   DataWidth  byte address; word index is address[$clog2(Depth)+1:2].
//  store_data  in   DataWidth  lane-aligned store data.
//  load_data   out  DataWidth  full read word; valid only while data_valid=1.
//  data_valid  out  1          one-cycle completion pulse for both loads and stores.
//  busy        out  1          1 from the accept edge until the cycle after data_valid.
//  mem_err     out  1          error flag; exists only when MEM_ERR_EN is defined.
// BEHAVIOUR
//  Reset (rst=0 at a clk edge): state becomes IDLE; data_valid, busy, load_data and mem_err are 0;
//   the latency counter is 0. Array contents are not reset. A reset mid-transaction abandons it:
//   no write occurs and no data_valid is produced.
//  FSM has three states: IDLE, WAIT, RESP.
//   IDLE: if request=1, capture we_re, mask, word index, store_data and (if enabled) the error
//    condition. Set busy=1. Go to RESP when Latency==1; otherwise load cnt=Latency-1 and go to WAIT.
//   WAIT: decrement cnt. Go to RESP when cnt reaches 1. Input changes are ignored, including
//    request dropping; the captured transaction always completes.
//   RESP: data_valid=1 for exactly this cycle. Store: write each lane with mask[i]=1 at this edge;
//    load_data=0. Load: load_data=array[captured index], the value before any write in this same
//    cycle. Next state is IDLE with busy=0. A request still high in RESP is not accepted; it is
//    accepted at the earliest in the following IDLE cycle.
//  Throughput: one transaction per Latency+1 cycles. Total latency from accept to data_valid is
//   exactly Latency cycles.
//  Store with mask=4'b0000 completes normally (data_valid pulses) and leaves the array unchanged.
//  The word index wraps modulo Depth; address bits [1:0] are ignored by the responder.
// CONFIGURATION
//  MEM_ERR_EN defined: an access with address >= Depth*4 is an error.
//   - The store is suppressed and the load returns 0.
//   - mem_err=1 in the RESP cycle together with data_valid.
//  MEM_ERR_EN undefined: the mem_err port is absent and out-of-range addresses wrap silently.
// STRUCTURE
//  mem_resp_pkg contains:
//   - typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_e
//   - localparam BYTE_LANES = 4
//   - typedef struct for the captured request (we, mask, idx, wdata).
//  Sub-module sram_bank: Depth x DataWidth array, synchronous byte-enable write, combinational read.
//   data_memory_responder owns only the FSM, the capture registers and the response path.
// TESTING
//  1. Latency=2. Store addr 0x10, data 0xDEADBEEF, mask 4'hF; then load 0x10.
//     -> data_valid exactly 2 cycles after each accept; load_data=0xDEADBEEF.
//  2. Word 0x10 holds 0xDEADBEEF. Store 0x000000AA with mask 4'b0001; load.
//     -> 0xDEADBEAA. Mask 4'b0000 leaves the word unchanged, but data_valid still pulses.
//  3. request held high continuously.
//     -> accepts are spaced Latency+1 cycles apart; exactly one data_valid per accept.
//  4. Assert rst=0 during WAIT of a store.
//     -> no data_valid; the word is unchanged; busy=0 and state is IDLE the next cycle.
//  5. Depth=1024, address 0x1000. With MEM_ERR_EN: mem_err=1, load_data=0, no write.
//     Without MEM_ERR_EN: the access aliases to word 0.
//  6. Latency=1: accept then data_valid on the next edge. Drop request during WAIT at Latency=4:
//     the transaction still completes.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types for the data-memory responder: FSM encoding and the captured request record.
// The MEM_ERR_EN build option only changes data_memory_responder; this package is build-independent.
package mem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_e;

  localparam int BYTE_LANES = 4;
  localparam int DATA_W     = 32;
  localparam int IDX_W      = 32;
  localparam int CNT_W      = 4;

  // idx is stored wide; the responder uses only the low $clog2(Depth) bits
  typedef struct packed {
    logic                  we;
    logic [BYTE_LANES-1:0] mask;
    logic                  err;
    logic [IDX_W-1:0]      idx;
    logic [DATA_W-1:0]     wdata;
  } mem_req_t;

endpackage

// File: rtl/sram_bank.sv
// Depth x DataWidth word array with synchronous byte-enable write and combinational read.
// Contents are never reset.
module sram_bank
  import mem_resp_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [BYTE_LANES-1:0]    i_be,
  input  logic [$clog2(Depth)-1:0] i_idx,
  input  logic [DataWidth-1:0]     i_wdata,
  output logic [DataWidth-1:0]     o_rdata
);

  logic [DataWidth-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_memory_responder.sv
// Responder for the core's data-memory requests: fixed-latency byte-masked store / word load.
// Define MEM_ERR_EN to add o_mem_err and flag/suppress accesses at or beyond Depth*4 bytes.
module data_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 1024,
  parameter int Latency   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_request,
  input  logic                  i_we_re,
  input  logic [BYTE_LANES-1:0] i_mask,
  input  logic [DataWidth-1:0]  i_address,
  input  logic [DataWidth-1:0]  i_store_data,
  output logic [DataWidth-1:0]  o_load_data,
  output logic                  o_data_valid,
  output logic                  o_busy
`ifdef MEM_ERR_EN
  ,
  output logic                  o_mem_err
`endif
);

  localparam int AW = $clog2(Depth);

  mem_resp_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  mem_req_t             r_req;
  logic                 w_accept;
  logic                 w_addr_err;
  logic                 w_resp;
  logic                 w_wr_en;
  logic [AW-1:0]        w_idx;
  logic [DataWidth-1:0] w_rdata;
  logic                 w_unused;

`ifdef MEM_ERR_EN
  assign w_addr_err = |i_address[DataWidth-1:AW+2];
`else
  assign w_addr_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_req.we    <= i_we_re;
        r_req.mask  <= i_mask;
        r_req.err   <= w_addr_err;
        r_req.idx   <= IDX_W'(i_address[AW+1:2]);
        r_req.wdata <= i_store_data;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_request) begin
          w_accept = 1'b1;
          if (Latency == 1) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_W'(Latency - 1);
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt <= CNT_W'(1)) w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_resp  = (r_state == RESP);
  assign w_wr_en = w_resp && r_req.we && !r_req.err;
  assign w_idx   = r_req.idx[AW-1:0];

  sram_bank #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_bank (
    .i_clk   (i_clk),
    .i_we    (w_wr_en),
    .i_be    (r_req.mask),
    .i_idx   (w_idx),
    .i_wdata (r_req.wdata),
    .o_rdata (w_rdata)
  );

  // read is combinational, so a load sees the word before any write at this edge
  assign o_load_data  = (w_resp && !r_req.we && !r_req.err) ? w_rdata : '0;
  assign o_data_valid = w_resp;
  assign o_busy       = (r_state != IDLE);
`ifdef MEM_ERR_EN
  assign o_mem_err    = w_resp && r_req.err;
`endif

  assign w_unused = ^{i_address[1:0], i_address[DataWidth-1:AW+2], r_req.idx[IDX_W-1:AW]};

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder (Latency=2), plus Latency=1 and Latency=4 timing checks.
// Builds with or without MEM_ERR_EN.
module tb_data_memory_responder;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  mask = '0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        dv, busy, merr;

  logic        s_req = 1'b0, s_we = 1'b0;
  logic [3:0]  s_mask = '0;
  logic [31:0] s_addr = '0, s_wdata = '0;
  logic [31:0] l1_rdata, l4_rdata;
  logic        l1_dv, l1_busy, l1_merr, l4_dv, l4_busy, l4_merr;

  data_memory_responder #(.DataWidth(32), .Depth(1024), .Latency(LAT)) u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_request(req), .i_we_re(we), .i_mask(mask),
    .i_address(addr), .i_store_data(wdata), .o_load_data(rdata), .o_data_valid(dv),
    .o_busy(busy)
`ifdef MEM_ERR_EN
    , .o_mem_err(merr)
`endif
  );

  data_memory_responder #(.DataWidth(32), .Depth(1024), .Latency(1)) u_l1 (
    .i_clk(clk), .i_rst(rst_n), .i_request(s_req), .i_we_re(s_we), .i_mask(s_mask),
    .i_address(s_addr), .i_store_data(s_wdata), .o_load_data(l1_rdata), .o_data_valid(l1_dv),
    .o_busy(l1_busy)
`ifdef MEM_ERR_EN
    , .o_mem_err(l1_merr)
`endif
  );

  data_memory_responder #(.DataWidth(32), .Depth(1024), .Latency(4)) u_l4 (
    .i_clk(clk), .i_rst(rst_n), .i_request(s_req), .i_we_re(s_we), .i_mask(s_mask),
    .i_address(s_addr), .i_store_data(s_wdata), .o_load_data(l4_rdata), .o_data_valid(l4_dv),
    .o_busy(l4_busy)
`ifdef MEM_ERR_EN
    , .o_mem_err(l4_merr)
`endif
  );

`ifndef MEM_ERR_EN
  assign merr = 1'b0;
  assign l1_merr = 1'b0;
  assign l4_merr = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   acc_log[$];
  int   cyc = 0;
  int   dv_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: logs accepts (busy rising) and checks every data_valid against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (busy && !prev_busy) begin
      acc_q.push_back(cyc);
      acc_log.push_back(cyc);
    end
    prev_busy = busy;
    if (dv) begin
      dv_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_dv: data_valid with no pending request (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("load_data", rdata, e.data);
`ifdef MEM_ERR_EN
        chk("mem_err", {31'b0, merr}, {31'b0, e.err});
`endif
        // accept edge k -> data_valid consumed at edge k+LAT, i.e. seen LAT-1 negedges later
        if (acc_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL latency: data_valid without an observed accept (cycle %0d)", cyc);
        end else begin
          chk("latency", cyc - acc_q.pop_front(), LAT - 1);
        end
      end
    end
  end

  task automatic run(input logic w, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic exp_e, input int n);
    exp_t e;
    int   target;
    e.data = exp_d;
    e.err  = exp_e;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
    target = dv_cnt + n;
    @(negedge clk);
    we = w; mask = m; addr = a; wdata = d; req = 1'b1;
    for (int t = 0; t < 20 * n && dv_cnt < target; t++) begin
      @(negedge clk);
      #1;
    end
    req = 1'b0;
    if (dv_cnt < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got %0d data_valid expected %0d", dv_cnt, target);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  // shared stimulus to the Latency=1 and Latency=4 instances; request drops right after accept
  task automatic lat_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d);
    int d1 = -1, d4 = -1, t0, n4 = 0;
    @(negedge clk);
    s_we = w; s_addr = a; s_wdata = d; s_mask = 4'hF; s_req = 1'b1;
    @(negedge clk);
    s_req = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      if (l1_dv && d1 < 0) begin
        d1 = cyc - t0;
        chk("l1_load_data", l1_rdata, exp_d);
      end
      if (l4_dv) begin
        n4++;
        if (d4 < 0) begin
          d4 = cyc - t0;
          chk("l4_load_data", l4_rdata, exp_d);
        end
      end
      @(negedge clk);
    end
    chk("l1_latency", d1, 0);
    chk("l4_latency", d4, 3);
    chk("l4_dv_count", n4, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_dv", {31'b0, dv}, 0);
    chk("rst_load_data", rdata, 0);
    chk("rst_mem_err", {31'b0, merr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // full-word store then load
    run(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    run(1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);

    // partial and empty masks
    run(1'b1, 4'b0001, 32'h10, 32'h000000AA, 32'h0, 1'b0, 1);
    run(1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEAA, 1'b0, 1);
    run(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0, 1);
    run(1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEAA, 1'b0, 1);
    run(1'b1, 4'b1010, 32'h12, 32'h11223344, 32'h0, 1'b0, 1);
    run(1'b0, 4'h0, 32'h13, 32'h0, 32'h11AD33AA, 1'b0, 1);

    // request held across three transactions
    run(1'b0, 4'h0, 32'h10, 32'h0, 32'h11AD33AA, 1'b0, 3);
    chk("accept_spacing_a", acc_log[$] - acc_log[$-1], LAT + 1);
    chk("accept_spacing_b", acc_log[$-1] - acc_log[$-2], LAT + 1);

    // reset during WAIT of a store abandons it
    run(1'b1, 4'hF, 32'h20, 32'h11111111, 32'h0, 1'b0, 1);
    @(negedge clk);
    we = 1'b1; mask = 4'hF; addr = 32'h20; wdata = 32'h22222222; req = 1'b1;
    @(negedge clk);
    chk("accept_busy", {31'b0, busy}, 1);
    rst_n = 1'b0;
    req = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_dv", {31'b0, dv}, 0);
    rst_n = 1'b1;
    acc_q.delete();
    repeat (3) @(negedge clk);
    run(1'b0, 4'h0, 32'h20, 32'h0, 32'h11111111, 1'b0, 1);

    // address beyond the array
    run(1'b1, 4'hF, 32'h0, 32'h01234567, 32'h0, 1'b0, 1);
`ifdef MEM_ERR_EN
    run(1'b1, 4'hF, 32'h1000, 32'h5A5A5A5A, 32'h0, 1'b1, 1);
    run(1'b0, 4'h0, 32'h0, 32'h0, 32'h01234567, 1'b0, 1);
    run(1'b0, 4'h0, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
`else
    run(1'b1, 4'hF, 32'h1000, 32'h5A5A5A5A, 32'h0, 1'b0, 1);
    run(1'b0, 4'h0, 32'h0, 32'h0, 32'h5A5A5A5A, 1'b0, 1);
    run(1'b0, 4'h0, 32'h1000, 32'h0, 32'h5A5A5A5A, 1'b0, 1);
`endif

    // Latency=1 and Latency=4 instances
    lat_txn(1'b1, 32'h40, 32'hCAFEF00D, 32'h0);
    lat_txn(1'b0, 32'h40, 32'h0, 32'hCAFEF00D);

    repeat (4) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
